// File: rtl/inst_encoder_if.sv
// Bundle between a field producer, the instruction encoder and instruction memory.
// Both sides use valid/ready. A transfer happens on a rising edge where valid and ready are both high. The producer holds its data stable until that edge.
interface inst_encoder_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 8
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            cond;
  logic [3:0]            op_code;
  logic [2:0]            dest_reg;
  logic [2:0]            src_reg_1;
  logic [2:0]            src_reg_2;
  logic                  shift;
  logic                  load_addr;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  mem_ready;
  logic [LEVEL_W-1:0]    level;
  logic                  wrapped;

  modport master (
    output in_valid, cond, op_code, dest_reg, src_reg_1, src_reg_2, shift,
    output load_addr, start_addr, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, level, wrapped
  );

  modport slave (
    input  in_valid, cond, op_code, dest_reg, src_reg_1, src_reg_2, shift,
    input  load_addr, start_addr, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, level, wrapped
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs instruction fields into 16-bit words, buffers them in a small FIFO,
// and writes them to instruction memory at an auto-incrementing address.
module inst_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 8
) (
  input logic             clk,
  input logic             reset_n,
  inst_encoder_if.slave   bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [15:0]           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [LEVEL_W-1:0]    count;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wrapped_q;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [15:0] word;

  assign full  = (count == LEVEL_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign word  = {bus.cond, bus.op_code, bus.dest_reg, bus.src_reg_1,
                  bus.src_reg_2, bus.shift};

  // Ready depends only on the registered occupancy. A pop in the same cycle does not free a slot for the input side.
  assign bus.in_ready  = !full && reset_n;
  assign bus.mem_we    = !empty && !bus.load_addr;
  assign bus.mem_wdata = empty ? 16'h0000 : fifo_mem[rd_ptr];
  assign bus.mem_addr  = addr_q;
  assign bus.level     = count;
  assign bus.wrapped   = wrapped_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.mem_we && bus.mem_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      addr_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LEVEL_W'(1);
        2'b01:   count <= count - LEVEL_W'(1);
        default: count <= count;
      endcase
      // load_addr suppresses mem_we, so a load and a pop never coincide.
      if (bus.load_addr) begin
        addr_q    <= bus.start_addr;
        wrapped_q <= 1'b0;
      end else if (pop) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        if (&addr_q) wrapped_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// Directed and random checks of inst_encoder against a queue-based model of the encoder's behaviour.
module tb_inst_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int W     = 16;

  logic clk;
  logic reset_n;

  inst_encoder_if #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();

  inst_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           m_addr;
  bit           m_wrapped;
  int           n_checks;
  int           n_fail;
  logic [W-1:0] saved_word;

  function automatic logic [W-1:0] pack(input logic [1:0] c, input logic [3:0] op,
                                        input logic [2:0] d, input logic [2:0] s1,
                                        input logic [2:0] s2, input logic sh);
    return {c, op, d, s1, s2, sh};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    bus.in_valid   = 1'b0;
    bus.load_addr  = 1'b0;
  endtask

  task automatic drive_push(input logic [1:0] c, input logic [3:0] op, input logic [2:0] d,
                            input logic [2:0] s1, input logic [2:0] s2, input logic sh);
    bus.in_valid  = 1'b1;
    bus.load_addr = 1'b0;
    bus.cond      = c;
    bus.op_code   = op;
    bus.dest_reg  = d;
    bus.src_reg_1 = s1;
    bus.src_reg_2 = s2;
    bus.shift     = sh;
  endtask

  task automatic drive_rand_push();
    drive_push(2'($urandom), 4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
  endtask

  task automatic drive_load(input logic [AW-1:0] a);
    bus.in_valid   = 1'b0;
    bus.load_addr  = 1'b1;
    bus.start_addr = a;
  endtask

  // Compares every output against the model, then advances one clock and updates the model.
  task automatic tick();
    bit           exp_ready;
    bit           exp_we;
    bit           do_push;
    bit           do_pop;
    logic [W-1:0] w;
    #1;
    exp_ready = reset_n && (exp_q.size() < DEPTH);
    exp_we    = (exp_q.size() != 0) && !bus.load_addr;
    check("in_ready",  bus.in_ready,  exp_ready);
    check("mem_we",    bus.mem_we,    exp_we);
    check("mem_wdata", bus.mem_wdata, (exp_q.size() != 0) ? exp_q[0] : 16'h0000);
    check("mem_addr",  bus.mem_addr,  m_addr);
    check("level",     bus.level,     exp_q.size());
    check("wrapped",   bus.wrapped,   m_wrapped);
    do_push = bus.in_valid && exp_ready;
    do_pop  = exp_we && bus.mem_ready;
    w = pack(bus.cond, bus.op_code, bus.dest_reg, bus.src_reg_1, bus.src_reg_2, bus.shift);
    @(posedge clk);
    if (!reset_n) begin
      exp_q.delete();
      m_addr    = 0;
      m_wrapped = 0;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(w);
      if (bus.load_addr) begin
        m_addr    = int'(bus.start_addr);
        m_wrapped = 0;
      end else if (do_pop) begin
        if (m_addr == (1 << AW) - 1) m_wrapped = 1;
        m_addr = (m_addr + 1) % (1 << AW);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.mem_ready  = 1'b1;
    bus.start_addr = '0;
    drive_push(2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    m_addr    = 0;
    m_wrapped = 0;

    // reset values
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // packing: AAAA, BBBB, CCCC at addresses 0..2
    drive_push(2'd2, 4'd10, 3'd5, 3'd2, 3'd5, 1'b0); tick();
    drive_idle(); #1;
    check("pack_aaaa", bus.mem_wdata, 16'hAAAA);
    check("pack_aaaa_addr", bus.mem_addr, 0);
    tick();
    drive_push(2'd2, 4'd14, 3'd7, 3'd3, 3'd5, 1'b1); tick();
    drive_idle(); #1;
    check("pack_bbbb", bus.mem_wdata, 16'hBBBB);
    check("pack_bbbb_addr", bus.mem_addr, 1);
    tick();
    drive_push(2'd3, 4'd3, 3'd1, 3'd4, 3'd6, 1'b0); tick();
    drive_idle(); #1;
    check("pack_cccc", bus.mem_wdata, 16'hCCCC);
    check("pack_cccc_addr", bus.mem_addr, 2);
    tick();

    // backpressure and full
    drive_load(8'h00); tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin drive_rand_push(); tick(); end
    drive_idle(); #1;
    check("full_level", bus.level, 4);
    check("full_in_ready", bus.in_ready, 0);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("drain_level", bus.level, 0);
    check("drain_addr", bus.mem_addr, 4);

    // simultaneous push and pop at level 2
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin drive_rand_push(); tick(); end
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin drive_rand_push(); tick(); end
    drive_idle(); #1;
    check("pushpop_level", bus.level, 2);
    for (int i = 0; i < 2; i++) tick();

    // push while full with a concurrent pop is rejected
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive_rand_push(); tick(); end
    bus.mem_ready = 1'b1;
    drive_rand_push(); tick();
    drive_idle(); #1;
    check("full_pop_level", bus.level, 3);
    for (int i = 0; i < 3; i++) tick();

    // address wrap
    drive_load(8'hFE); tick();
    for (int i = 0; i < 3; i++) begin drive_rand_push(); tick(); end
    drive_idle();
    for (int i = 0; i < 3; i++) tick();
    check("wrap_flag", bus.wrapped, 1);
    check("wrap_addr", bus.mem_addr, 1);
    drive_load(8'h10); tick();
    drive_idle(); #1;
    check("wrap_cleared", bus.wrapped, 0);

    // load while non-empty
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin drive_rand_push(); tick(); end
    saved_word = exp_q[0];
    bus.mem_ready = 1'b1;
    drive_load(8'h40); #1;
    check("load_we_off", bus.mem_we, 0);
    tick();
    drive_idle(); #1;
    check("load_addr", bus.mem_addr, 8'h40);
    check("load_head", bus.mem_wdata, saved_word);
    for (int i = 0; i < 2; i++) tick();

    // reset mid-operation
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive_rand_push(); tick(); end
    drive_idle();
    bus.mem_ready = 1'b1; #1;
    check("pre_reset_we", bus.mem_we, 1);
    reset_n = 1'b0; tick();
    check("rst_we", bus.mem_we, 0);
    check("rst_level", bus.level, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_in_ready", bus.in_ready, 0);
    tick();
    reset_n = 1'b1; tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) drive_load(AW'($urandom));
      else if ($urandom_range(0, 2) != 0) drive_rand_push();
      else drive_idle();
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 63) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Packs decoded instruction fields (cond, op_code, dest_reg, src_reg_1, src_reg_2, shift) into 16-bit instruction words. Buffers the words in a small FIFO and writes them sequentially into instruction memory through an auto-incrementing address counter. It is the program-loading counterpart of the instruction decoder: any word it emits, when fed to the decoder, reproduces the original fields.

## Interface
- FIFO_DEPTH, 4, number of buffered words (power of two, ≥2)
- ADDR_WIDTH, 8, instruction memory address width

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  one clock; reset is synchronous and active-low
- in_valid  in  1  field set on inputs is valid
- in_ready  out  1  encoder can accept a field set
- cond  in  2  condition field
- op_code  in  4  opcode field
- dest_reg  in  3  destination register
- src_reg_1  in  3  first source register
- src_reg_2  in  3  second source register
- shift  in  1  shift flag
- load_addr  in  1  pulse: load write address from start_addr
- start_addr  in  ADDR_WIDTH  base address for load_addr
- mem_we  out  1  write request, valid word at mem_addr/mem_wdata
- mem_addr  out  ADDR_WIDTH  write address
- mem_wdata  out  16  packed instruction word
- mem_ready  in  1  memory accepts write this cycle
- level  out  clog2(FIFO_DEPTH)+1  words currently buffered
- wrapped  out  1  sticky: address counter wrapped past all-ones

## Operation
- Packing: word = {cond[15:14], op_code[13:10], dest_reg[9:7], src_reg_1[6:4], src_reg_2[3:1], shift[0]}. No field checking.
- Input handshake: a push occurs on a rising edge where in_valid && in_ready. in_ready = !full && reset_n. Fields are sampled only at the push edge.
- Output handshake: mem_we = !empty && !load_addr. A pop/write occurs on an edge where mem_we && mem_ready. mem_addr then increments by 1, modulo 2^ADDR_WIDTH.
- mem_wdata = head entry when non-empty, 16'h0000 when empty. mem_addr/mem_wdata are stable while mem_we is high and mem_ready is low.
- FIFO: circular, read/write pointers wrap at FIFO_DEPTH. level = pushes − pops. A simultaneous push and pop leaves level unchanged.
- Full: in_ready=0, including in a cycle where a pop also occurs (no pass-through to the input side). Empty: no pop, no bypass from input to output.
- Address wrap: a pop at mem_addr = all-ones moves the counter to 0 and sets wrapped. wrapped clears only on reset or load_addr.
- load_addr: at the edge, the counter is set to start_addr and wrapped is cleared. mem_we is forced 0 in that cycle, so no write occurs. FIFO contents are untouched. Pushes are unaffected.
- Reset (reset_n low at an edge): pointers=0, level=0, mem_addr=0, wrapped=0. FIFO contents are discarded, including mid-transfer words.

## Timing
- Reset values, from the first edge with reset_n low: in_ready=0 (combinational with reset_n), mem_we=0, mem_addr=0, mem_wdata=16'h0000, level=0, wrapped=0.
- Latency: a word pushed at edge N appears on mem_wdata with mem_we=1 in the cycle after N, with earliest memory write at edge N+1 if the FIFO was empty.
- Throughput: 1 word/cycle sustained when mem_ready is held high.
- in_ready and mem_we derive from registered pointers only, plus load_addr/reset_n. There is no combinational path from in_valid to mem_we or from mem_ready to in_ready.

## Test plan
- Pack: push fields cond=2, op=10, dest=5, src1=2, src2=5, shift=0 with mem_ready=1 -> one cycle later mem_we=1, mem_wdata=16'hAAAA, mem_addr=0. Repeat with fields giving 16'hBBBB and 16'hCCCC at addr 1 and 2.
- Backpressure/full: mem_ready=0, push 5 consecutive cycles -> 4 words accepted, in_ready=0 from the cycle after the 4th push, level=4. Release mem_ready -> words written in order to addr 0..3 on consecutive edges.
- Simultaneous push/pop at level=2 with mem_ready=1 -> level stays 2 and order is preserved. Push attempt while full with a concurrent pop -> rejected.
- Wrap: load_addr with start_addr=8'hFE, then push 3 words -> writes at FE, FF, 00, and wrapped=1 after the FF write. A later load_addr clears it.
- load_addr while non-empty with mem_ready=1 -> mem_we=0 that cycle, and the next write goes to start_addr with the same head word.
- Reset mid-operation: reset_n low with level=3 and mem_we=1 -> at the next edge mem_we=0, level=0, mem_addr=0, in_ready=0 until reset_n returns high.
